// File: rtl/mul_share_pkg.sv
// Shared types, defaults and round-robin pick helper for the
// shared-multiplier arbiter.
package mul_share_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_ID_W    = 2;
    localparam int MAX_REQ     = 8;

    typedef struct packed {
        logic                   valid;
        logic [DEF_ID_W-1:0]    id;
        logic [2*DEF_WIDTH-1:0] prod;
    } stage_t;

    // Returns {found, idx}; search starts at ptr+1 and wraps modulo n.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_REQ-1:0] valid_vec,
        input logic [2:0]         ptr,
        input int unsigned        n
    );
        logic [3:0]  res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) j = j - n;
            if (k <= n && !res[3] && valid_vec[j[2:0]]) begin
                res = {1'b1, j[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its index,
// searching from the requester after ptr.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [MAX_REQ-1:0] vec;
    logic [3:0]         pick;

    // Pick the next valid requester after ptr; gate grant with enable
    always_comb begin
        vec = '0;
        vec[NUM_REQ-1:0] = req;
        pick = rr_pick(vec, 3'(ptr), NUM_REQ);
        grant_idx = ID_W'(pick[2:0]);
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = enable && pick[3] && (pick[2:0] == 3'(i));
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// One pipelined unsigned multiplier shared round-robin among NUM_REQ
// requesters; results return tagged with the requester ID.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = DEF_LATENCY,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic                     hold,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_data,
    output logic [2:0]               in_flight,
    output logic                     idle
);

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [2*WIDTH-1:0] prod;
    } pipe_t;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               issue;
    logic [WIDTH-1:0]   a_sel, b_sel;
    pipe_t              head_d;
    pipe_t              stg_q [LATENCY];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (rst_n && !hold),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign issue     = |grant;

    // Select the winner's operands and form the full-width product
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
        head_d.valid = issue;
        head_d.id    = grant_idx;
        head_d.prod  = {{WIDTH{1'b0}}, a_sel} * {{WIDTH{1'b0}}, b_sel};
    end

    // Next pointer and occupancy count
    always_comb begin
        ptr_d = issue ? grant_idx : ptr_q;
        cnt_d = cnt_q + 3'(issue) - 3'(resp_valid);
    end

    // Pointer and occupancy registers; requester 0 first after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar s = 0; s < LATENCY; s++) begin : g_pipe
        pipe_t in_d;
        if (s == 0) begin : g_head
            assign in_d = head_d;
        end else begin : g_tail
            assign in_d = stg_q[s-1];
        end

        // Stage register; payload only moves with a valid op so the
        // last stage holds its result while idle
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stg_q[s] <= '0;
            end else begin
                stg_q[s].valid <= in_d.valid;
                if (in_d.valid) begin
                    stg_q[s].id   <= in_d.id;
                    stg_q[s].prod <= in_d.prod;
                end
            end
        end
    end

    assign resp_valid = stg_q[LATENCY-1].valid;
    assign resp_id    = stg_q[LATENCY-1].id;
    assign resp_data  = stg_q[LATENCY-1].prod;
    assign in_flight  = cnt_q;
    assign idle       = (cnt_q == 3'd0) && !(|req_valid);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with default
// parameters (3 requesters, 8-bit operands, latency 2).
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [23:0] req_a = '0;
    logic [23:0] req_b = '0;
    logic        hold = 1'b0;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [15:0] resp_data;
    logic [2:0]  in_flight;
    logic        idle;

    int n_assert = 0;
    int n_fail   = 0;

    int rr_ifl [9]  = '{1, 2, 2, 2, 2, 2, 1, 0, 0};
    int rr_prod [3] = '{6, 20, 42};
    int hold_ifl [3] = '{1, 0, 0};

    mul_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .hold       (hold),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .in_flight  (in_flight),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with all requesters asking
        rst_n = 1'b0;
        req_valid = 3'b111;
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_rv", resp_valid, 0);
        check("rst_ifl", in_flight, 0);
        check("rst_data", resp_data, 0);
        check("rst_id", resp_id, 0);
        rst_n = 1'b1;
        req_valid = 3'b000;
        #1;
        check("rst_idle", idle, 1);

        // single issue from requester 1: 12*11
        req_a[15:8] = 8'd12;
        req_b[15:8] = 8'd11;
        req_valid = 3'b010;
        #1;
        check("t1_ready", req_ready, 3'b010);
        check("t1_notidle", idle, 0);
        tick();
        req_valid = 3'b000;
        check("t1_ifl_a", in_flight, 1);
        check("t1_rv_a", resp_valid, 0);
        tick();
        check("t1_rv", resp_valid, 1);
        check("t1_id", resp_id, 1);
        check("t1_data", resp_data, 132);
        check("t1_ifl_b", in_flight, 1);
        tick();
        check("t1_rv_end", resp_valid, 0);
        check("t1_ifl_c", in_flight, 0);
        check("t1_data_hold", resp_data, 132);

        // full width: 255*255 from requester 0
        req_a[7:0] = 8'hFF;
        req_b[7:0] = 8'hFF;
        req_valid = 3'b001;
        #1;
        check("fw_ready", req_ready, 3'b001);
        tick();
        req_valid = 3'b000;
        tick();
        check("fw_rv", resp_valid, 1);
        check("fw_id", resp_id, 0);
        check("fw_data", resp_data, 16'hFE01);
        tick();

        // round robin: reset pointer, then all valid for 6 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a = {8'd6, 8'd4, 8'd2};
        req_b = {8'd7, 8'd5, 8'd3};
        for (int c = 0; c < 9; c++) begin
            req_valid = (c < 6) ? 3'b111 : 3'b000;
            #1;
            check($sformatf("rr_ready%0d", c), req_ready,
                  (c < 6) ? (32'd1 << (c % 3)) : 32'd0);
            tick();
            if (c >= 1 && c <= 6) begin
                check($sformatf("rr_rv%0d", c), resp_valid, 1);
                check($sformatf("rr_id%0d", c), resp_id, (c - 1) % 3);
                check($sformatf("rr_data%0d", c), resp_data,
                      rr_prod[(c - 1) % 3]);
            end else begin
                check($sformatf("rr_rv%0d", c), resp_valid, 0);
            end
            check($sformatf("rr_ifl%0d", c), in_flight, rr_ifl[c]);
        end

        // hold: grant 0, then hold 3 cycles, then resume at 1
        req_valid = 3'b111;
        #1;
        check("hold_g0", req_ready, 3'b001);
        tick();
        hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            #1;
            check($sformatf("hold_ready%0d", h), req_ready, 0);
            tick();
            if (h == 0) begin
                check("hold_rv", resp_valid, 1);
                check("hold_id", resp_id, 0);
                check("hold_data", resp_data, 6);
            end else begin
                check($sformatf("hold_rv%0d", h), resp_valid, 0);
            end
            check($sformatf("hold_ifl%0d", h), in_flight, hold_ifl[h]);
        end
        hold = 1'b0;
        #1;
        check("hold_resume", req_ready, 3'b010);
        tick();
        req_valid = 3'b000;
        tick();
        tick();

        // reset mid-flight: two ops in the pipe, then reset
        req_valid = 3'b001;
        #1;
        check("mf_ready0", req_ready, 3'b001);
        tick();
        req_valid = 3'b100;
        #1;
        check("mf_ready1", req_ready, 3'b100);
        tick();
        check("mf_ifl", in_flight, 2);
        rst_n = 1'b0;
        req_valid = 3'b000;
        tick();
        check("mf_rst_ifl", in_flight, 0);
        check("mf_rst_rv", resp_valid, 0);
        rst_n = 1'b1;
        tick();
        check("mf_rv_a", resp_valid, 0);
        tick();
        check("mf_rv_b", resp_valid, 0);
        check("mf_ifl_b", in_flight, 0);
        req_valid = 3'b111;
        #1;
        check("mf_ptr", req_ready, 3'b001);

        // dropout: park pointer on 2, then 0 wins while 2 drops out
        req_valid = 3'b100;
        #1;
        check("do_ready2", req_ready, 3'b100);
        tick();
        req_a[7:0] = 8'd9;
        req_b[7:0] = 8'd10;
        req_valid = 3'b101;
        #1;
        check("do_ready0", req_ready, 3'b001);
        tick();
        check("do_rv_a", resp_valid, 1);
        check("do_id_a", resp_id, 2);
        check("do_data_a", resp_data, 42);
        req_valid = 3'b001;
        #1;
        check("do_only0", req_ready, 3'b001);
        tick();
        check("do_rv_b", resp_valid, 1);
        check("do_id_b", resp_id, 0);
        check("do_data_b", resp_data, 90);
        req_valid = 3'b000;
        #1;
        check("do_busy", idle, 0);
        tick();
        check("do_rv_c", resp_valid, 1);
        check("do_id_c", resp_id, 0);
        check("do_ifl_c", in_flight, 1);
        tick();
        check("do_rv_end", resp_valid, 0);
        check("do_ifl_end", in_flight, 0);
        check("do_idle", idle, 1);
        tick();
        check("do_quiet", resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
